// File: rtl/bcd_a_binario_secuencial_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Holds the FSM state encoding, the default sizing of the converter
// and the width of its iteration counter.
package bcd_a_binario_secuencial_pkg;

  // FSM state encoding, also driven out on the debug port as raw bits.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } estado_t;

  // Default sizing: three digits (000..999) fit in ten binary bits.
  localparam int NUM_DIGITS_DEF = 3;
  localparam int BIN_WIDTH_DEF  = 10;

  // Counter width for the default size: ceil(log2(BIN_WIDTH_DEF + 1)).
  localparam int CNT_W_DEF = $clog2(BIN_WIDTH_DEF + 1);

endpackage

// File: rtl/bcd_a_binario_secuencial_correccion.sv
// correccion_digito_bcd
// Per-digit correction step of reverse double dabble. After the
// right shift a digit that reached 8 or more carries an extra weight
// from the upper digit that belongs to the binary side, so 3 is
// taken off (modulo 16). Digits below 8 pass unchanged, so the
// subtraction can never underflow.
// Ports:
//   d : shifted BCD digit
//   q : corrected BCD digit
module correccion_digito_bcd (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule

// File: rtl/bcd_a_binario_secuencial.sv
// bcd_a_binario_secuencial
// Sequential BCD-to-binary converter (reverse double dabble: shift
// right, then subtract 3 from every BCD digit that is 8 or more).
// A scratch register {bcd, bin} is shifted once per clock for
// BIN_WIDTH clocks; the bin half then holds the binary value.
//
// Handshake with the controller: a request is the level of inicio
// sampled on a rising edge while the FSM is in IDLE; that edge is the
// acceptance and bcdEntrada is captured on it. inicio is ignored in
// any other state (no queuing). ocupado is high for every SHIFT cycle;
// listo is high for exactly one cycle when binario/errorBCD are valid,
// after which the converter is back in IDLE and may accept again.
//
// Ports:
//   clkNexys2  : system clock, rising edge
//   Reset      : asynchronous active-low reset
//   inicio     : start request
//   bcdEntrada : packed digits, bits [3:0] are unidades
//   binario    : converted value, held until the next result
//   ocupado    : conversion in progress
//   listo      : one-cycle result-valid pulse
//   errorBCD   : some input digit was above 9, held with binario
//   estado     : current FSM state (debug)
module bcd_a_binario_secuencial
  import bcd_a_binario_secuencial_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int BIN_WIDTH  = BIN_WIDTH_DEF
) (
  input  logic                    clkNexys2,
  input  logic                    Reset,
  input  logic                    inicio,
  input  logic [4*NUM_DIGITS-1:0] bcdEntrada,
  output logic [BIN_WIDTH-1:0]    binario,
  output logic                    ocupado,
  output logic                    listo,
  output logic                    errorBCD,
  output logic [1:0]              estado
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SCR_W = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  estado_t state, next_state;

  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] shifted;
  logic [SCR_W-1:0] corrected;
  logic [CNT_W-1:0] cnt;
  logic             digits_ok;
  logic             last_iter;

  // All digits must be 0..9 for the conversion to be meaningful.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcdEntrada[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  // One iteration: shift the whole register right, then correct each
  // BCD digit of the shifted value. The bin half needs no correction.
  assign shifted = scratch >> 1;
  assign corrected[BIN_WIDTH-1:0] = shifted[BIN_WIDTH-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_corr
    correccion_digito_bcd u_corr (
      .d (shifted[BIN_WIDTH + 4*g +: 4]),
      .q (corrected[BIN_WIDTH + 4*g +: 4])
    );
  end

  // The iteration performed in this SHIFT cycle is the last one.
  assign last_iter = (cnt == CNT_W'(BIN_WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clkNexys2 or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state and Moore outputs.
  always_comb begin
    next_state = state;
    ocupado    = 1'b0;
    listo      = 1'b0;
    case (state)
      IDLE: begin
        if (inicio) next_state = digits_ok ? SHIFT : DONE;
      end
      SHIFT: begin
        ocupado = 1'b1;
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        listo      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign estado = state;

  // Datapath: scratch register, iteration counter and held results.
  // binario/errorBCD are only written on the edge that enters DONE.
  always_ff @(posedge clkNexys2 or negedge Reset) begin
    if (!Reset) begin
      scratch  <= '0;
      cnt      <= '0;
      binario  <= '0;
      errorBCD <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inicio) begin
            if (digits_ok) begin
              scratch <= {bcdEntrada, {BIN_WIDTH{1'b0}}};
              cnt     <= '0;
            end else begin
              errorBCD <= 1'b1;
              binario  <= '0;
            end
          end
        end
        SHIFT: begin
          scratch <= corrected;
          cnt     <= cnt + CNT_W'(1);
          if (last_iter) begin
            binario  <= corrected[BIN_WIDTH-1:0];
            errorBCD <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
